mem_responder: RTL and testbench

- Memory-side responder for the controller's memory control outputs: `load_addr`, `sel_addr` and `ram_w_en`.
- Captures an address from either the PC path or the datapath, and services one word read or write after a fixed, parameterised latency.
- Holds the word storage array internally.
- Reports completion through one-cycle `rd_valid`/`wr_done` pulses, and reports bad accesses through `err`. The controller holds in a waiting state while `busy` is high.

---
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_responder.sv | 99 +++++++++
 tb/tb_mem_responder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle between the memory controller and the word-memory responder.
interface mem_responder_if;
   logic        load_addr;
   logic        sel_addr;
   logic        ram_w_en;
   logic [31:0] pc_addr;
   logic [31:0] dp_addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        wr_done;
   logic        busy;
   logic        err;

   modport master (
      output load_addr, sel_addr, ram_w_en, pc_addr, dp_addr, wr_data,
      input  rd_data, rd_valid, wr_done, busy, err
   );

   modport slave (
      input  load_addr, sel_addr, ram_w_en, pc_addr, dp_addr, wr_data,
      output rd_data, rd_valid, wr_done, busy, err
   );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word memory that services one read or write per request after a fixed latency,
// with one-cycle completion/error pulses and a busy flag that stalls the controller.
module mem_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   mem_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t        state_q, state_d;
   logic [31:0]   addr_q, addr_d, wd_q, wd_d, rd_data_q, rd_data_d;
   logic          we_q, we_d, rd_valid_q, rd_valid_d, wr_done_q, wr_done_d, err_q, err_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [31:0]   mem [DEPTH];
   logic          accept, complete, c_we, c_bad, mem_we;
   logic [31:0]   req_addr, c_addr, c_wd;
   logic [AW-1:0] idx;

   assign accept   = (state_q != WAIT) && bus.load_addr;
   assign req_addr = bus.sel_addr ? bus.dp_addr : bus.pc_addr;
   // A single-cycle request completes on its own accept edge, so it is served from the live inputs
   assign c_addr   = (LATENCY == 1) ? req_addr : addr_q;
   assign c_we     = (LATENCY == 1) ? bus.ram_w_en : we_q;
   assign c_wd     = (LATENCY == 1) ? bus.wr_data : wd_q;
   assign complete = (LATENCY == 1) ? accept : (state_q == WAIT && cnt_q == 4'd1);
   assign c_bad    = (c_addr[1:0] != 2'd0) || ({2'b0, c_addr[31:2]} >= 32'(DEPTH));
   assign idx      = c_addr[AW+1:2];
   assign mem_we   = complete && !c_bad && c_we;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wd_d       = wd_q;
      cnt_d      = cnt_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      wr_done_d  = 1'b0;
      err_d      = 1'b0;
      if (accept) begin
         addr_d  = req_addr;
         we_d    = bus.ram_w_en;
         wd_d    = bus.wr_data;
         cnt_d   = 4'(LATENCY - 1);
         state_d = (LATENCY > 1) ? WAIT : DONE;
      end else if (state_q == WAIT) begin
         cnt_d   = cnt_q - 4'd1;
         state_d = (cnt_q == 4'd1) ? DONE : WAIT;
      end else begin
         state_d = IDLE;
      end
      if (complete) begin
         err_d      = c_bad;
         wr_done_d  = !c_bad && c_we;
         rd_valid_d = !c_bad && !c_we;
         rd_data_d  = (!c_bad && !c_we) ? mem[idx] : rd_data_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wd_q       <= '0;
         cnt_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         wr_done_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wd_q       <= wd_d;
         cnt_q      <= cnt_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         wr_done_q  <= wr_done_d;
         err_q      <= err_d;
      end
   end

   // Storage is deliberately not reset; an aborted request never reaches mem_we
   always_ff @(posedge clk) begin
      if (mem_we) mem[idx] <= c_wd;
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.wr_done  = wr_done_q;
   assign bus.err      = err_q;
   assign bus.busy     = (state_q == WAIT);
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed vector table, hand-written corner sequences and a randomized run
// checked against a cycle-indexed request/completion model of the responder.
module tb_mem_responder;
   localparam int DEPTH = 256;
   localparam int L     = 2;

   typedef struct {
      logic        we;
      logic        sel;
      logic [31:0] a;
      logic [31:0] wd;
      logic [2:0]  exp;
      logic [31:0] rd;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   passes = 0;

   mem_responder_if bus ();

   mem_responder #(.DEPTH(DEPTH), .LATENCY(L)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] pulses();
      return 32'({bus.err, bus.wr_done, bus.rd_valid});
   endfunction

   task automatic do_req(input logic we, input logic sel, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] exp, input logic [31:0] exp_rd, input string nm);
      bus.load_addr = 1'b1;
      bus.sel_addr  = sel;
      bus.ram_w_en  = we;
      bus.dp_addr   = sel ? a : $urandom;
      bus.pc_addr   = sel ? $urandom : a;
      bus.wr_data   = wd;
      step();
      bus.load_addr = 1'b0;
      for (int k = 0; k < L - 1; k++) begin
         chk({nm, " wait"}, 32'({bus.busy, pulses()}), 32'({1'b1, 32'd0}));
         step();
      end
      chk({nm, " done"}, 32'({bus.busy, pulses()}), 32'({1'b0, 29'd0, exp}));
      chk({nm, " rd_data"}, bus.rd_data, exp_rd);
   endtask

   vec_t        tbl [14];
   logic [31:0] m [DEPTH];
   logic [31:0] m_rd, a, wd, rq_a, rq_wd;
   logic [2:0]  e;
   logic        ld, we, rq_we;
   int          r, last_c, last_e0, npulse;

   initial begin
      tbl[0]  = '{1'b1, 1'b1, 32'h0,        32'h0BADF00D, 3'b010, 32'h0};
      tbl[1]  = '{1'b1, 1'b1, 32'h10,       32'hDEADBEEF, 3'b010, 32'h0};
      tbl[2]  = '{1'b0, 1'b0, 32'h10,       32'h0,        3'b001, 32'hDEADBEEF};
      tbl[3]  = '{1'b0, 1'b0, 32'h12,       32'h0,        3'b100, 32'hDEADBEEF};
      tbl[4]  = '{1'b1, 1'b1, 32'h400,      32'h55555555, 3'b100, 32'hDEADBEEF};
      tbl[5]  = '{1'b0, 1'b0, 32'h0,        32'h0,        3'b001, 32'h0BADF00D};
      tbl[6]  = '{1'b1, 1'b0, 32'h8,        32'hCAFEF00D, 3'b010, 32'h0BADF00D};
      tbl[7]  = '{1'b0, 1'b1, 32'h8,        32'h0,        3'b001, 32'hCAFEF00D};
      tbl[8]  = '{1'b0, 1'b1, 32'hFFFFFFFC, 32'h0,        3'b100, 32'hCAFEF00D};
      tbl[9]  = '{1'b1, 1'b0, 32'h3FC,      32'h11112222, 3'b010, 32'hCAFEF00D};
      tbl[10] = '{1'b0, 1'b1, 32'h3FC,      32'h0,        3'b001, 32'h11112222};
      tbl[11] = '{1'b1, 1'b1, 32'h3FD,      32'h0,        3'b100, 32'h11112222};
      tbl[12] = '{1'b1, 1'b1, 32'h20,       32'hA5A5A5A5, 3'b010, 32'h11112222};
      tbl[13] = '{1'b0, 1'b0, 32'h20,       32'h0,        3'b001, 32'hA5A5A5A5};

      bus.load_addr = 1'b0;
      bus.sel_addr  = 1'b0;
      bus.ram_w_en  = 1'b0;
      bus.pc_addr   = '0;
      bus.dp_addr   = '0;
      bus.wr_data   = '0;
      #3 rst_n = 1'b0;
      #1;
      chk("reset outputs", 32'({bus.busy, pulses()}), 32'd0);
      chk("reset rd_data", bus.rd_data, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      step();

      // Consecutive table entries are issued back-to-back from each DONE cycle
      for (int i = 0; i < 14; i++)
         do_req(tbl[i].we, tbl[i].sel, tbl[i].a, tbl[i].wd, tbl[i].exp, tbl[i].rd, $sformatf("vec%0d", i));

      // A request strobed during WAIT must be dropped, leaving the original address in force
      bus.load_addr = 1'b1; bus.sel_addr = 1'b0; bus.pc_addr = 32'h10; bus.ram_w_en = 1'b0;
      step();
      chk("ignore wait", 32'({bus.busy, pulses()}), 32'({1'b1, 32'd0}));
      bus.load_addr = 1'b1; bus.sel_addr = 1'b1; bus.dp_addr = 32'h20; bus.ram_w_en = 1'b1; bus.wr_data = 32'h0;
      step();
      bus.load_addr = 1'b0;
      chk("ignore done", pulses(), 32'b001);
      chk("ignore rd_data", bus.rd_data, 32'hDEADBEEF);
      npulse = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         npulse += (pulses() != 0) ? 1 : 0;
      end
      chk("ignore extra pulses", 32'(npulse), 32'd0);
      do_req(1'b0, 1'b1, 32'h20, 32'h0, 3'b001, 32'hA5A5A5A5, "ignore reread");

      // Reset during WAIT aborts the pending write
      bus.load_addr = 1'b1; bus.sel_addr = 1'b1; bus.dp_addr = 32'h8; bus.ram_w_en = 1'b1; bus.wr_data = 32'h12345678;
      step();
      bus.load_addr = 1'b0;
      chk("abort busy", 32'(bus.busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort reset outputs", 32'({bus.busy, pulses()}), 32'd0);
      chk("abort reset rd_data", bus.rd_data, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      npulse = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         npulse += (pulses() != 0) ? 1 : 0;
      end
      chk("abort no pulse", 32'(npulse), 32'd0);
      do_req(1'b0, 1'b0, 32'h8, 32'h0, 3'b001, 32'hCAFEF00D, "abort reread");

      m_rd = 32'hCAFEF00D;
      for (int w = 0; w < 8; w++) begin
         m[w] = $urandom;
         do_req(1'b1, 1'(w & 1), 32'(w * 4), m[w], 3'b010, m_rd, $sformatf("preload%0d", w));
      end
      step();

      last_c  = -1;
      last_e0 = -1;
      rq_we   = 1'b0;
      rq_a    = '0;
      rq_wd   = '0;
      for (int n = 0; n < 400; n++) begin
         ld = ($urandom_range(0, 9) < 6);
         r  = $urandom_range(0, 9);
         a  = (r < 8) ? 32'(r * 4)
            : (r == 8) ? 32'($urandom_range(0, 7) * 4 + $urandom_range(1, 3))
            : 32'h400 + 32'($urandom_range(0, 1000) * 4);
         we = 1'($urandom_range(0, 1));
         wd = $urandom;
         bus.load_addr = ld;
         bus.sel_addr  = 1'($urandom_range(0, 1));
         bus.dp_addr   = bus.sel_addr ? a : $urandom;
         bus.pc_addr   = bus.sel_addr ? $urandom : a;
         bus.ram_w_en  = we;
         bus.wr_data   = wd;
         step();
         if (ld && n > last_c) begin
            rq_we = we; rq_a = a; rq_wd = wd;
            last_e0 = n;
            last_c  = n + L - 1;
         end
         e = 3'b000;
         if (n == last_c) begin
            if (rq_a[1:0] != 2'd0 || rq_a / 4 >= DEPTH) e = 3'b100;
            else if (rq_we) begin
               m[rq_a / 4] = rq_wd;
               e = 3'b010;
            end else begin
               m_rd = m[rq_a / 4];
               e = 3'b001;
            end
         end
         chk($sformatf("rnd%0d pulses", n), pulses(), 32'(e));
         chk($sformatf("rnd%0d busy", n), 32'(bus.busy), 32'(n >= last_e0 && n < last_c));
         chk($sformatf("rnd%0d rd_data", n), bus.rd_data, m_rd);
      end
      bus.load_addr = 1'b0;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
